// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin picker; grant bit 0 = fetch port, bit 1 = data port.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  grant_e     i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      // On a tie the port that did not win last time goes first.
      2'b11:   o_grant = (i_last_grant == GRANT_D) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data port arbiter onto one memory bus (IDLE -> ACCESS -> DONE).
// Optional ACCESS watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_read_enable,
  input  logic [31:0] if_address,
  output logic [31:0] if_read_data,
  output logic        if_read_data_valid,
  input  logic        d_read_enable,
  input  logic        d_write_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_write_data,
  output logic [31:0] d_read_data,
  output logic        d_read_data_valid,
  output logic        d_write_done,
  output logic        if_error,
  output logic        d_error,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_data_valid,
  input  logic        mem_write_done
);

  state_e      r_state;
  grant_e      r_grant;
  grant_e      r_last_grant;
  logic        r_op_write;

  logic [1:0]  w_req;
  logic [1:0]  w_grant;
  grant_e      w_win;
  logic        w_win_write;
  logic        w_done;
  logic        w_timeout;
  logic        w_finish;
  logic [31:0] w_rdata;

  assign w_req = {d_read_enable | d_write_enable, if_read_enable};

  rr_arbiter2 u_rr_arbiter2 (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_win       = w_grant[1] ? GRANT_D : GRANT_IF;
  assign w_win_write = (w_win == GRANT_D) && d_write_enable;
  // Only the response matching the issued op counts; the other kind is ignored.
  assign w_done      = r_op_write ? mem_write_done : mem_read_data_valid;
  assign w_finish    = w_done || w_timeout;
  assign w_rdata     = w_done ? mem_read_data : 32'd0;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TC_LOAD = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tcnt;

  assign w_timeout = (r_state == ACCESS) && (r_tcnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt <= '0;
    end else if (r_state == IDLE) begin
      r_tcnt <= TC_LOAD;
    end else if (r_state == ACCESS && r_tcnt != '0) begin
      r_tcnt <= r_tcnt - 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state            <= IDLE;
      r_grant            <= GRANT_IF;
      r_last_grant       <= GRANT_D;
      r_op_write         <= 1'b0;
      mem_read_enable    <= 1'b0;
      mem_write_enable   <= 1'b0;
      mem_address        <= 32'd0;
      mem_write_data     <= 32'd0;
      if_read_data       <= 32'd0;
      if_read_data_valid <= 1'b0;
      if_error           <= 1'b0;
      d_read_data        <= 32'd0;
      d_read_data_valid  <= 1'b0;
      d_write_done       <= 1'b0;
      d_error            <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_grant          <= w_win;
            r_last_grant     <= w_win;
            r_op_write       <= w_win_write;
            mem_address      <= (w_win == GRANT_D) ? d_address : if_address;
            mem_write_data   <= (w_win == GRANT_D) ? d_write_data : 32'd0;
            mem_read_enable  <= !w_win_write;
            mem_write_enable <= w_win_write;
            r_state          <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_finish) begin
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            r_state          <= DONE;
            if (r_grant == GRANT_IF) begin
              if_read_data_valid <= 1'b1;
              if_read_data       <= w_rdata;
              if_error           <= !w_done;
            end else begin
              d_error <= !w_done;
              if (r_op_write) begin
                d_write_done <= 1'b1;
              end else begin
                d_read_data_valid <= 1'b1;
                d_read_data       <= w_rdata;
              end
            end
          end
        end
        DONE: begin
          if_read_data_valid <= 1'b0;
          if_error           <= 1'b0;
          d_read_data_valid  <= 1'b0;
          d_write_done       <= 1'b0;
          d_error            <= 1'b0;
          r_state            <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small latency-programmable memory model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_read_enable = 1'b0;
  logic [31:0] if_address = '0;
  logic [31:0] if_read_data;
  logic        if_read_data_valid;
  logic        d_read_enable = 1'b0;
  logic        d_write_enable = 1'b0;
  logic [31:0] d_address = '0;
  logic [31:0] d_write_data = '0;
  logic [31:0] d_read_data;
  logic        d_read_data_valid;
  logic        d_write_done;
  logic        if_error;
  logic        d_error;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        mem_read_data_valid = 1'b0;
  logic        mem_write_done = 1'b0;

  int checks = 0;
  int failures = 0;
  int mem_lat = 1;
  bit mem_stall = 1'b0;
  int mem_cnt = 0;
  bit mem_responded = 1'b0;

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .if_read_enable      (if_read_enable),
    .if_address          (if_address),
    .if_read_data        (if_read_data),
    .if_read_data_valid  (if_read_data_valid),
    .d_read_enable       (d_read_enable),
    .d_write_enable      (d_write_enable),
    .d_address           (d_address),
    .d_write_data        (d_write_data),
    .d_read_data         (d_read_data),
    .d_read_data_valid   (d_read_data_valid),
    .d_write_done        (d_write_done),
    .if_error            (if_error),
    .d_error             (d_error),
    .mem_read_enable     (mem_read_enable),
    .mem_write_enable    (mem_write_enable),
    .mem_address         (mem_address),
    .mem_write_data      (mem_write_data),
    .mem_read_data       (mem_read_data),
    .mem_read_data_valid (mem_read_data_valid),
    .mem_write_done      (mem_write_done)
  );

  always #5 clk = ~clk;

  // Memory answers mem_lat cycles after the request appears, unless stalled.
  always @(negedge clk) begin
    if (!reset_n || !(mem_read_enable || mem_write_enable)) begin
      mem_read_data_valid = 1'b0;
      mem_write_done      = 1'b0;
      mem_read_data       = '0;
      mem_cnt             = 0;
      mem_responded       = 1'b0;
    end else if (!mem_stall && !mem_responded) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_responded = 1'b1;
        if (mem_read_enable) begin
          mem_read_data_valid = 1'b1;
          mem_read_data = (mem_address == 32'h100) ? 32'h0640_0093 : (mem_address ^ 32'hA5A5_0000);
        end else begin
          mem_write_done = 1'b1;
        end
      end
    end else begin
      mem_read_data_valid = 1'b0;
      mem_write_done      = 1'b0;
    end
  end

  task automatic wait_resp(input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk); #1;
      if (if_read_data_valid || d_read_data_valid || d_write_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_read_enable, mem_write_enable, if_read_data_valid, d_read_data_valid, d_write_done, if_error, d_error} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0", {mem_read_enable, mem_write_enable, if_read_data_valid, d_read_data_valid, d_write_done, if_error, d_error});
    end
    checks++;
    if ({mem_address, mem_write_data, if_read_data, d_read_data} !== 128'b0) begin
      failures++;
      $display("FAIL reset_data addr=%h wd=%h ifd=%h dd=%h exp=0", mem_address, mem_write_data, if_read_data, d_read_data);
    end
    do_reset();
  endtask

  task automatic test_fetch_read();
    int cyc;
    mem_lat = 1;
    @(negedge clk);
    if_address = 32'h100;
    if_read_enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_read_enable !== 1'b1 || mem_write_enable !== 1'b0 || mem_address !== 32'h100) begin
      failures++;
      $display("FAIL fetch_issue re=%b we=%b addr=%h exp re=1 we=0 addr=00000100", mem_read_enable, mem_write_enable, mem_address);
    end
    wait_resp(20, cyc);
    checks++;
    if (cyc !== 1) begin
      failures++;
      $display("FAIL fetch_latency got=%0d exp=1", cyc);
    end
    checks++;
    if (if_read_data_valid !== 1'b1 || if_read_data !== 32'h0640_0093 || d_read_data_valid !== 1'b0 || if_error !== 1'b0) begin
      failures++;
      $display("FAIL fetch_resp v=%b data=%h dv=%b err=%b exp v=1 data=06400093 dv=0 err=0", if_read_data_valid, if_read_data, d_read_data_valid, if_error);
    end
    @(negedge clk);
    if_read_enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (if_read_data_valid !== 1'b0 || mem_read_enable !== 1'b0) begin
      failures++;
      $display("FAIL fetch_pulse_width v=%b re=%b exp 0 0", if_read_data_valid, mem_read_enable);
    end
  endtask

  task automatic test_data_write();
    int cyc;
    mem_lat = 3;
    @(negedge clk);
    d_address = 32'hCC;
    d_write_data = 32'd12345;
    d_write_enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0 || mem_address !== 32'hCC || mem_write_data !== 32'd12345) begin
      failures++;
      $display("FAIL write_issue we=%b re=%b addr=%h wd=%0d exp we=1 re=0 addr=000000cc wd=12345", mem_write_enable, mem_read_enable, mem_address, mem_write_data);
    end
    wait_resp(20, cyc);
    checks++;
    if (cyc !== 3) begin
      failures++;
      $display("FAIL write_latency got=%0d exp=3", cyc);
    end
    checks++;
    if (d_write_done !== 1'b1 || d_read_data_valid !== 1'b0 || if_read_data_valid !== 1'b0 || if_read_data !== 32'h0640_0093) begin
      failures++;
      $display("FAIL write_resp done=%b dv=%b iv=%b ifd=%h exp done=1 dv=0 iv=0 ifd=06400093", d_write_done, d_read_data_valid, if_read_data_valid, if_read_data);
    end
    @(negedge clk);
    d_write_enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (d_write_done !== 1'b0) begin
      failures++;
      $display("FAIL write_pulse_width got=%b exp=0", d_write_done);
    end
    mem_lat = 1;
  endtask

  task automatic test_round_robin();
    int cyc;
    do_reset();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      if_address = 32'h200;
      d_address = 32'h300;
      if_read_enable = 1'b1;
      d_read_enable = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (mem_address !== 32'h200) begin
        failures++;
        $display("FAIL tie%0d_first got=%h exp=00000200", t, mem_address);
      end
      wait_resp(20, cyc);
      checks++;
      if (if_read_data_valid !== 1'b1 || d_read_data_valid !== 1'b0 || if_read_data !== 32'hA5A5_0200) begin
        failures++;
        $display("FAIL tie%0d_fetch_resp iv=%b dv=%b data=%h exp 1 0 a5a50200", t, if_read_data_valid, d_read_data_valid, if_read_data);
      end
      @(negedge clk);
      if_read_enable = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      checks++;
      if (mem_address !== 32'h300 || mem_read_enable !== 1'b1) begin
        failures++;
        $display("FAIL tie%0d_second addr=%h re=%b exp 00000300 1", t, mem_address, mem_read_enable);
      end
      wait_resp(20, cyc);
      checks++;
      if (d_read_data_valid !== 1'b1 || if_read_data_valid !== 1'b0 || d_read_data !== 32'hA5A5_0300) begin
        failures++;
        $display("FAIL tie%0d_data_resp dv=%b iv=%b data=%h exp 1 0 a5a50300", t, d_read_data_valid, if_read_data_valid, d_read_data);
      end
      @(negedge clk);
      d_read_enable = 1'b0;
    end
  endtask

  task automatic test_read_write_both();
    int cyc;
    @(negedge clk);
    d_address = 32'h40;
    d_write_data = 32'hDEAD_BEEF;
    d_read_enable = 1'b1;
    d_write_enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0 || mem_write_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL both_issue we=%b re=%b wd=%h exp 1 0 deadbeef", mem_write_enable, mem_read_enable, mem_write_data);
    end
    wait_resp(20, cyc);
    checks++;
    if (d_write_done !== 1'b1 || d_read_data_valid !== 1'b0 || d_read_data !== 32'hA5A5_0300) begin
      failures++;
      $display("FAIL both_resp done=%b dv=%b dd=%h exp 1 0 a5a50300", d_write_done, d_read_data_valid, d_read_data);
    end
    @(negedge clk);
    d_read_enable = 1'b0;
    d_write_enable = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    mem_stall = 1'b1;
    @(negedge clk);
    d_address = 32'h600;
    d_read_enable = 1'b1;
    @(posedge clk); #1;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_resp(30, cyc);
    checks++;
    if (cyc !== 8) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=8", cyc);
    end
    checks++;
    if (d_read_data_valid !== 1'b1 || d_error !== 1'b1 || d_read_data !== 32'd0 || if_error !== 1'b0 || mem_read_enable !== 1'b0) begin
      failures++;
      $display("FAIL timeout_resp dv=%b err=%b dd=%h ierr=%b re=%b exp 1 1 0 0 0", d_read_data_valid, d_error, d_read_data, if_error, mem_read_enable);
    end
    @(negedge clk);
    d_read_enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (d_error !== 1'b0 || d_read_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width err=%b dv=%b exp 0 0", d_error, d_read_data_valid);
    end
`else
    wait_resp(20, cyc);
    checks++;
    if (cyc !== -1 || mem_read_enable !== 1'b1 || mem_address !== 32'h600 || d_error !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout_wait resp=%0d re=%b addr=%h err=%b exp -1 1 00000600 0", cyc, mem_read_enable, mem_address, d_error);
    end
    @(negedge clk);
    d_read_enable = 1'b0;
    do_reset();
`endif
    mem_stall = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    mem_stall = 1'b1;
    @(negedge clk);
    d_address = 32'h500;
    d_read_enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (mem_read_enable !== 1'b1 || mem_address !== 32'h500 || d_read_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold re=%b addr=%h dv=%b exp 1 00000500 0", mem_read_enable, mem_address, d_read_data_valid);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_read_enable !== 1'b0 || mem_address !== 32'd0 || if_read_data !== 32'd0 || d_read_data !== 32'd0) begin
      failures++;
      $display("FAIL async_reset re=%b addr=%h ifd=%h dd=%h exp all 0", mem_read_enable, mem_address, if_read_data, d_read_data);
    end
    @(negedge clk);
    d_read_enable = 1'b0;
    mem_stall = 1'b0;
    reset_n = 1'b1;
    wait_resp(6, cyc);
    checks++;
    if (cyc !== -1 || mem_read_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_pulse resp=%0d re=%b exp -1 0", cyc, mem_read_enable);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write();
    test_round_robin();
    test_read_write_both();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time limit reached");
    $fatal(1, "simulation time limit");
  end

endmodule
